alu_ctrl: RTL and testbench

Sequencing controller that shares the combinational 16-bit ALU (F[4:0], Cin, Result, Status[5:0] = {C,Z,N,V,P,A}) with a command stream.
- Holds a 4-entry 16-bit register file and a 6-bit FLAGS register.
- Accepts one command at a time over valid/ready, drives the ALU with registered operands and forwards FLAGS.C as Cin.
- Writes the result back and returns result plus status over a valid/ready response channel.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_regfile.sv | 32 +++
 rtl/alu_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, flag bit
// positions, controller states and the opcode legality check.
package alu_pkg;

  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;
  localparam logic [4:0] OP_MOV = 5'b10000;
  localparam logic [4:0] OP_SHL = 5'b10001;
  localparam logic [4:0] OP_SHR = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam int FLG_C = 5;
  localparam int FLG_Z = 4;
  localparam int FLG_N = 3;
  localparam int FLG_V = 2;
  localparam int FLG_P = 1;
  localparam int FLG_A = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Holes in the map: 00000, 00010, 01100-01111 and 11000-11111.
  function automatic logic is_legal_op(input logic [4:0] f);
    return !((f == 5'b00000) || (f == 5'b00010) ||
             (f[4:2] == 3'b011) || (f[4:3] == 2'b11));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, cleared to zero by synchronous reset.
module alu_regfile #(
  parameter int NREG = 4,
  parameter int W    = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  logic [W-1:0] mem [NREG];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer for an external combinational ALU: registers operands,
// chains carry through FLAGS, writes results back and returns a response.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  // Both channels: a transfer happens on a rising edge where valid & ready;
  // valid never depends on ready, and payload is held while valid is high.
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic          cmd_ld,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic          cmd_imm_en,
  input  logic [W-1:0]  cmd_imm,
  input  logic          cmd_wb,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [4:0]    alu_f,
  output logic          alu_cin,
  input  logic [W-1:0]  alu_result,
  input  logic [5:0]    alu_status,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_result,
  output logic [5:0]    rsp_flags,
  output logic          rsp_err,
  output state_t        dbg_state
);

  state_t        state;
  logic [5:0]    flags;
  logic [AW-1:0] dst_q;
  logic          wb_q;
  logic [W-1:0]  rd_a, rd_b;
  logic          legal;
  logic          accept_ld;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign alu_cin   = flags[FLG_C];
  assign dbg_state = state;
  assign legal     = is_legal_op(alu_f);
  assign accept_ld = (state == IDLE) && cmd_valid && cmd_ld;

  // Loads write at the accept edge; ALU results write at the end of EXEC.
  assign rf_we    = accept_ld || ((state == EXEC) && legal && wb_q);
  assign rf_waddr = (state == IDLE) ? cmd_dst : dst_q;
  assign rf_wdata = (state == IDLE) ? cmd_imm : alu_result;

  alu_regfile #(.NREG(NREG), .W(W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (cmd_dst),
    .raddr_b (cmd_src),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flags      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_f      <= '0;
      dst_q      <= '0;
      wb_q       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a <= rd_a;
            alu_b <= cmd_imm_en ? cmd_imm : rd_b;
            alu_f <= cmd_op;
            dst_q <= cmd_dst;
            wb_q  <= cmd_wb;
            if (cmd_ld) begin
              rsp_result <= cmd_imm;
              rsp_flags  <= flags;
              rsp_err    <= 1'b0;
              state      <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          if (legal) begin
            flags     <= alu_status;
            rsp_flags <= alu_status;
            rsp_err   <= 1'b0;
          end else begin
            rsp_flags <= flags;
            rsp_err   <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU beside the controller, vector table
// with scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int W    = 16;
  localparam int NREG = 4;
  localparam int EW   = W + 7;

  typedef struct {
    logic [4:0]   op;
    logic         ld;
    logic [1:0]   dst;
    logic [1:0]   src;
    logic         imm_en;
    logic [W-1:0] imm;
    logic         wb;
    logic [W-1:0] res;
    logic [5:0]   flg;
    logic         err;
    int           lat;
    logic         chk_cin;
    logic         exp_cin;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [4:0]   cmd_op;
  logic         cmd_ld;
  logic [1:0]   cmd_dst, cmd_src;
  logic         cmd_imm_en;
  logic [W-1:0] cmd_imm;
  logic         cmd_wb;
  logic [W-1:0] alu_a, alu_b;
  logic [4:0]   alu_f;
  logic         alu_cin;
  logic [W-1:0] alu_result;
  logic [5:0]   alu_status;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic [5:0]   rsp_flags;
  logic         rsp_err;
  state_t       dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  vec_t vecs[15];

  alu_ctrl #(.NREG(NREG), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ld(cmd_ld), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Behavioural ALU: arithmetic/logic subset; illegal codes give a marker value.
  logic [16:0]  m_s;
  logic [W-1:0] m_res, m_x;
  logic         m_c, m_v, m_aux;
  always_comb begin
    m_s = '0; m_res = alu_a; m_x = '0; m_c = 1'b0; m_v = 1'b0; m_aux = 1'b0;
    case (alu_f)
      OP_ADD, OP_ADC: begin
        m_s   = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, (alu_f == OP_ADC) & alu_cin};
        m_res = m_s[15:0];
        m_c   = m_s[16];
        m_v   = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
        m_x   = alu_a ^ alu_b ^ m_res;
        m_aux = m_x[4];
      end
      OP_SUB, OP_SBB: begin
        m_s   = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, (alu_f == OP_SBB) & alu_cin};
        m_res = m_s[15:0];
        m_c   = m_s[16];
        m_v   = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_a[15]);
        m_x   = alu_a ^ alu_b ^ m_res;
        m_aux = m_x[4];
      end
      OP_AND: m_res = alu_a & alu_b;
      OP_OR:  m_res = alu_a | alu_b;
      OP_XOR: m_res = alu_a ^ alu_b;
      default: m_res = alu_a;
    endcase
    alu_result = m_res;
    alu_status = {m_c, m_res == '0, m_res[15], m_v, ~^m_res[7:0], m_aux};
    if (!is_legal_op(alu_f)) begin
      alu_result = alu_a + 16'h1234;
      alu_status = 6'h3F;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic ld, input logic [1:0] dst,
                              input logic [1:0] src, input logic imm_en, input logic [W-1:0] imm,
                              input logic wb, input logic [W-1:0] res, input logic [5:0] flg,
                              input logic err, input int lat, input logic chk_cin,
                              input logic exp_cin);
    vec_t v;
    v.op = op; v.ld = ld; v.dst = dst; v.src = src; v.imm_en = imm_en; v.imm = imm;
    v.wb = wb; v.res = res; v.flg = flg; v.err = err; v.lat = lat;
    v.chk_cin = chk_cin; v.exp_cin = exp_cin;
    return v;
  endfunction

  // Driver: issue one command, measure latency, optionally stall the response.
  task automatic run_cmd(input vec_t v, input int stall);
    int lat;
    logic exec_cin;
    logic [EW-1:0] exp;
    exec_cin = 1'bx;
    exp_q.push_back({v.err, v.flg, v.res});
    @(negedge clk);
    cmd_op = v.op; cmd_ld = v.ld; cmd_dst = v.dst; cmd_src = v.src;
    cmd_imm_en = v.imm_en; cmd_imm = v.imm; cmd_wb = v.wb; cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 20) begin @(negedge clk); lat++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      if (dbg_state == EXEC) exec_cin = alu_cin;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    if (!rsp_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    if (v.chk_cin) chk("exec_cin", 32'(exec_cin), 32'(v.exp_cin));
    if (stall > 0) begin
      cmd_op = OP_ADD; cmd_ld = 1'b1; cmd_dst = 2'd0; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_stable", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp_q[0]));
        chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
      end
    end
    exp = exp_q.pop_front();
    chk("response", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp));
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = '0; cmd_ld = 1'b0;
    cmd_dst = '0; cmd_src = '0; cmd_imm_en = 1'b0; cmd_imm = '0; cmd_wb = 1'b0;

    //          op      ld dst src ie imm       wb res       flg    er lat cc ec
    vecs[0]  = mk(5'd0,  1, 0, 0, 0, 16'h7FFF, 0, 16'h7FFF, 6'h00, 0, 1, 0, 0);
    vecs[1]  = mk(5'd0,  1, 1, 0, 0, 16'h0001, 0, 16'h0001, 6'h00, 0, 1, 0, 0);
    vecs[2]  = mk(OP_ADD, 0, 0, 1, 0, 16'h0000, 1, 16'h8000, 6'h0F, 0, 2, 0, 0);
    vecs[3]  = mk(OP_AND, 0, 0, 0, 1, 16'hFFFF, 0, 16'h8000, 6'h0A, 0, 2, 0, 0);
    vecs[4]  = mk(5'd0,  1, 2, 0, 0, 16'hFFFF, 0, 16'hFFFF, 6'h0A, 0, 1, 0, 0);
    vecs[5]  = mk(OP_ADD, 0, 2, 0, 1, 16'h0001, 1, 16'h0000, 6'h33, 0, 2, 0, 0);
    vecs[6]  = mk(OP_ADC, 0, 3, 0, 1, 16'h0000, 1, 16'h0001, 6'h00, 0, 2, 1, 1);
    vecs[7]  = mk(5'b11000, 0, 1, 1, 0, 16'h0000, 1, 16'h1235, 6'h00, 1, 2, 0, 0);
    vecs[8]  = mk(OP_AND, 0, 1, 0, 1, 16'hFFFF, 0, 16'h0001, 6'h00, 0, 2, 0, 0);
    vecs[9]  = mk(5'd0,  1, 3, 0, 0, 16'h56BC, 0, 16'h56BC, 6'h00, 0, 1, 0, 0);
    vecs[10] = mk(OP_SUB, 0, 3, 0, 1, 16'h47CD, 0, 16'h0EEF, 6'h01, 0, 2, 0, 0);
    vecs[11] = mk(OP_AND, 0, 3, 0, 1, 16'hFFFF, 0, 16'h56BC, 6'h00, 0, 2, 0, 0);
    vecs[12] = mk(OP_SUB, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 6'h12, 0, 2, 0, 0);
    vecs[13] = mk(OP_AND, 0, 0, 0, 1, 16'hFFFF, 0, 16'h0000, 6'h12, 0, 2, 0, 0);
    vecs[14] = mk(OP_XOR, 0, 1, 0, 1, 16'h8001, 1, 16'h8000, 6'h0A, 0, 2, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", 32'({rsp_err, rsp_flags, rsp_result}), 32'd0);
    chk("rst_alu_ops", 32'({alu_f, alu_cin}), 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_cmd(vecs[i], $urandom_range(0, 2) == 0 ? 1 : 0);

    // Backpressure: response held for five cycles while a command is offered.
    run_cmd(mk(5'd0, 1, 1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 6'h0A, 0, 1, 0, 0), 0);
    run_cmd(mk(OP_AND, 0, 1, 0, 1, 16'h00FF, 1, 16'h00FF, 6'h02, 0, 2, 0, 0), 5);
    chk("post_stall_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    chk("post_stall_no_accept", 32'({rsp_valid, dbg_state}), 32'({1'b0, IDLE}));
    run_cmd(mk(5'd0, 1, 0, 0, 0, 16'h1357, 0, 16'h1357, 6'h02, 0, 1, 0, 0), 0);
    run_cmd(mk(5'd0, 1, 2, 0, 0, 16'h2468, 0, 16'h2468, 6'h02, 0, 1, 0, 0), 0);

    // Reset lands while an ADD is in EXEC.
    @(negedge clk);
    cmd_op = OP_ADD; cmd_ld = 1'b0; cmd_dst = 2'd0; cmd_src = 2'd1;
    cmd_imm_en = 1'b0; cmd_wb = 1'b1; cmd_valid = 1'b1;
    chk("mid_rst_accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_rst_in_exec", 32'(dbg_state), 32'(EXEC));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_err, rsp_flags, rsp_result}), 32'd0);
    chk("mid_rst_alu", 32'({alu_f, alu_cin}), 32'd0);
    chk("mid_rst_alu_ab", {alu_a, alu_b}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    // Illegal op echoes reg[dst]+0x1234 with FLAGS untouched: shows r0 and FLAGS cleared.
    run_cmd(mk(5'b11111, 0, 0, 1, 0, 16'h0000, 1, 16'h1234, 6'h00, 1, 2, 0, 0), 0);
    for (int r = 1; r < NREG; r++)
      run_cmd(mk(OP_AND, 0, 2'(r), 0, 1, 16'hFFFF, 0, 16'h0000, 6'h12, 0, 2, 0, 0), 0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
